hazard_unit: RTL
================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter MUL_CYCLES, default 4, multiply busy length in cycles (range 1..63).
REQ-002 Parameter DIV_CYCLES, default 32, divide busy length in cycles (range 1..63).
REQ-003 clock  input  1  sole clock; all state changes on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 id_rs, id_rt  input  5 each  source register numbers of the instruction in ID.
REQ-006 id_use_rs, id_use_rt  input  1 each  ID instruction actually reads rs / rt.
REQ-007 id_branch  input  1  ID instruction is a branch/jr resolved in ID (needs operands in ID).
REQ-008 id_muldiv, id_div  input  1 each  ID instruction is mult/div; id_div=1 selects divide.
REQ-009 id_mfhilo  input  1  ID instruction reads HI/LO.
REQ-010 ex_write_reg  input  5;  ex_reg_write, ex_mem_read  input  1 each  EX-stage destination, write enable, load flag.
REQ-011 mem_write_reg  input  5;  mem_mem_read  input  1  MEM-stage destination, load flag.
REQ-012 pc_en, ifid_en  output  1 each  enable PC and IF/ID register update.
REQ-013 idex_bubble  output  1  force ID/EX register to a NOP.
REQ-014 md_start  output  1  one-cycle pulse launching the mul/div unit.
REQ-015 md_busy  output  1  mul/div unit occupied.
REQ-016 md_done  output  1  registered one-cycle pulse after the last busy cycle.
REQ-017 stall_cycles  output  16  saturating count of stalled cycles.

Function
REQ-018 Register match term: rs_hit(X) = id_use_rs and X!=0 and X==id_rs; rt_hit likewise; hit(X) = rs_hit or rt_hit.
REQ-019 load_use = ex_mem_read and ex_reg_write and hit(ex_write_reg).
REQ-020 br_ex = id_branch and ex_reg_write and hit(ex_write_reg) (EX result not yet forwardable to ID).
REQ-021 br_mem = id_branch and mem_mem_read and hit(mem_write_reg).
REQ-022 md_conflict = md_busy and (id_muldiv or id_mfhilo).
REQ-023 stall = load_use or br_ex or br_mem or md_conflict, combinational in the same cycle.
REQ-024 stall=1 -> pc_en=0, ifid_en=0, idex_bubble=1; stall=0 -> pc_en=1, ifid_en=1, idex_bubble=0.
REQ-025 FSM states IDLE, BUSY; md_busy=1 exactly when state is BUSY.
REQ-026 md_start = id_muldiv and not stall and state IDLE, combinational.
REQ-027 IDLE with md_start -> next BUSY, 6-bit counter loaded with DIV_CYCLES if id_div else MUL_CYCLES.
REQ-028 BUSY: counter decrements each cycle; when counter==1, next state IDLE, counter 0, md_done=1 next cycle.
REQ-029 BUSY lasts exactly MUL_CYCLES or DIV_CYCLES cycles after the md_start cycle.
REQ-030 Last BUSY cycle with id_muldiv/id_mfhilo present -> still stall that cycle; accepted the following cycle in IDLE.
REQ-031 Data-hazard stall and id_muldiv together -> no md_start; launch deferred until stall clears.
REQ-032 md_done=0 in every cycle except the one following the BUSY->IDLE transition.
REQ-033 stall_cycles increments by 1 each cycle with stall=1; holds at 16'hFFFF.
REQ-034 Register 0 never causes a hazard, regardless of write enables.

Reset
REQ-035 resetn low forces immediately: state IDLE, counter 0, md_done 0, stall_cycles 0, md_busy 0.
REQ-036 Reset during BUSY abandons the operation; no md_done pulse follows.
REQ-037 After reset with all inputs 0: pc_en=1, ifid_en=1, idex_bubble=0, md_start=0.

Verification
REQ-038 Load-use: ex_mem_read=1, ex_reg_write=1, ex_write_reg=8, id_rs=8, id_use_rs=1 -> pc_en=0, ifid_en=0, idex_bubble=1 one cycle; stall_cycles=1.
REQ-039 Zero register: same as REQ-038 with register 0 on both sides -> no stall.
REQ-040 Branch: id_branch=1, id_rt=5, id_use_rt=1, ex_reg_write=1, ex_write_reg=5 -> stall; next cycle mem_mem_read=1, mem_write_reg=5 -> stall; then stall clears.
REQ-041 Multiply: id_muldiv=1, id_div=0 at cycle T -> md_start at T, md_busy T+1..T+4, md_done at T+5; id_mfhilo at T+2 stalls through T+4.
REQ-042 Divide then back-to-back: divide at T, second id_muldiv held from T+1 -> stall T+1..T+32, md_done and second md_start both at T+33.
REQ-043 resetn low at T+10 of a divide -> md_busy 0 immediately, no md_done; saturation: 70000 forced stall cycles -> stall_cycles=16'hFFFF.

Source files
------------

// File: rtl/hazard_unit.sv
// hazard_unit
// Pipeline hazard detection and multiply/divide occupancy tracking.
// Combinationally decides whether the instruction in ID must stall (load-use,
// branch operand not yet available in ID, or mul/div unit conflict), gates
// the front-end enables, launches the mul/div unit and counts stall cycles.
//
// Ports
//   clock          in   sole clock, rising edge
//   resetn         in   asynchronous active-low reset
//   id_rs, id_rt   in   source registers of the ID instruction
//   id_use_rs/rt   in   ID instruction reads rs / rt
//   id_branch      in   ID instruction resolves in ID (branch / jr)
//   id_muldiv      in   ID instruction is mult/div
//   id_div         in   selects divide when id_muldiv is set
//   id_mfhilo      in   ID instruction reads HI/LO
//   ex_write_reg   in   EX destination register
//   ex_reg_write   in   EX writes a register
//   ex_mem_read    in   EX instruction is a load
//   mem_write_reg  in   MEM destination register
//   mem_mem_read   in   MEM instruction is a load
//   pc_en, ifid_en out  PC and IF/ID update enables
//   idex_bubble    out  squash ID/EX to a NOP
//   md_start       out  one-cycle mul/div launch
//   md_busy        out  mul/div unit occupied
//   md_done        out  registered pulse after the final busy cycle
//   stall_cycles   out  saturating stall counter
//
// state | meaning
// IDLE  | mul/div unit free, may accept a launch
// BUSY  | mul/div unit running, counter holds remaining cycles
module hazard_unit #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_branch,
    input  logic        id_muldiv,
    input  logic        id_div,
    input  logic        id_mfhilo,
    input  logic [4:0]  ex_write_reg,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic [4:0]  mem_write_reg,
    input  logic        mem_mem_read,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_bubble,
    output logic        md_start,
    output logic        md_busy,
    output logic        md_done,
    output logic [15:0] stall_cycles
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [5:0] MUL_LEN = 6'(MUL_CYCLES);
    localparam logic [5:0] DIV_LEN = 6'(DIV_CYCLES);

    state_t     state, state_next;
    logic [5:0] cnt, cnt_next;
    logic       done_next;

    logic ex_hit, mem_hit;
    logic load_use, br_ex, br_mem, md_conflict, stall;

    // Register 0 is hardwired, so it can never carry a dependency.
    assign ex_hit  = (ex_write_reg != 5'd0) &&
                     ((id_use_rs && (ex_write_reg == id_rs)) ||
                      (id_use_rt && (ex_write_reg == id_rt)));
    assign mem_hit = (mem_write_reg != 5'd0) &&
                     ((id_use_rs && (mem_write_reg == id_rs)) ||
                      (id_use_rt && (mem_write_reg == id_rt)));

    assign load_use    = ex_mem_read && ex_reg_write && ex_hit;
    // A branch in ID cannot take an EX result by forwarding yet.
    assign br_ex       = id_branch && ex_reg_write && ex_hit;
    assign br_mem      = id_branch && mem_mem_read && mem_hit;
    assign md_conflict = md_busy && (id_muldiv || id_mfhilo);
    assign stall       = load_use || br_ex || br_mem || md_conflict;

    assign pc_en       = !stall;
    assign ifid_en     = !stall;
    assign idex_bubble = stall;
    assign md_busy     = (state == BUSY);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        done_next  = 1'b0;
        md_start   = 1'b0;
        case (state)
            IDLE: begin
                if (id_muldiv && !stall) begin
                    md_start   = 1'b1;
                    state_next = BUSY;
                    cnt_next   = id_div ? DIV_LEN : MUL_LEN;
                end
            end
            BUSY: begin
                if (cnt == 6'd1) begin
                    state_next = IDLE;
                    cnt_next   = 6'd0;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt - 6'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            cnt     <= 6'd0;
            md_done <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            md_done <= done_next;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_cycles <= 16'd0;
        end else if (stall && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule
